// File: rtl/led_pwm_engine.sv
// rtl/led_pwm_engine.sv - multi-channel LED PWM engine with shadow duties and period-aligned fading
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data shadow duty write (addresses >= CH_NUM are dropped)
//   commit                  request to apply the shadow duties at the next period boundary
//   fade_en, fade_step      ramp control, sampled only at period boundaries (step 0 acts as 1)
//   period_start_o          one-cycle pulse after each period boundary
//   busy_o                  high while a commit or fade is outstanding
//   led_pwm_o               registered PWM outputs, one per channel

module led_pwm_engine #(
    parameter int CH_NUM   = 16,
    parameter int PWM_BITS = 8,
    parameter int ADDR_W   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PWM_BITS-1:0] wr_data,
    input  logic                commit,
    input  logic                fade_en,
    input  logic [PWM_BITS-1:0] fade_step,
    output logic                period_start_o,
    output logic                busy_o,
    output logic [CH_NUM-1:0]   led_pwm_o
);

    localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_FADING  = 2'd2;

    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_cnt;
    logic [1:0]          r_state;
    logic                r_pend;
    logic [PWM_BITS-1:0] r_shadow [CH_NUM];
    logic [PWM_BITS-1:0] r_active [CH_NUM];
    logic [PWM_BITS-1:0] r_target [CH_NUM];

    logic                w_tick;
    logic                w_boundary;
    logic                w_addr_ok;
    logic [PWM_BITS-1:0] w_step;
    logic [PWM_BITS-1:0] w_tgt_eff [CH_NUM];
    logic [PWM_BITS-1:0] w_next    [CH_NUM];
    logic                w_all_eq;

    assign w_tick     = (r_presc == PS_MAX);
    assign w_boundary = w_tick && (r_cnt == CNT_MAX);
    assign w_addr_ok  = (32'(wr_addr) < CH_NUM);
    assign busy_o     = (r_state != S_IDLE);

    // Timebase: prescaler feeding the free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            period_start_o <= 1'b0;
        end else begin
            r_presc        <= w_tick ? '0 : r_presc + PS_W'(1);
            period_start_o <= w_boundary;
            if (w_tick) begin
                r_cnt <= r_cnt + PWM_BITS'(1);
            end
        end
    end

    // One ramp step per channel. A pending commit retargets to the shadow
    // at this same boundary, so the step is taken toward the new target and
    // can never overshoot it.
    always_comb begin
        w_step   = (fade_step == '0) ? PWM_BITS'(1) : fade_step;
        w_all_eq = 1'b1;
        for (int i = 0; i < CH_NUM; i++) begin
            w_tgt_eff[i] = r_pend ? r_shadow[i] : r_target[i];
            if (r_active[i] < w_tgt_eff[i]) begin
                w_next[i] = ((w_tgt_eff[i] - r_active[i]) > w_step) ?
                            (r_active[i] + w_step) : w_tgt_eff[i];
            end else begin
                w_next[i] = ((r_active[i] - w_tgt_eff[i]) > w_step) ?
                            (r_active[i] - w_step) : w_tgt_eff[i];
            end
            w_all_eq = w_all_eq && (w_next[i] == w_tgt_eff[i]);
        end
    end

    // Shadow/active/target storage and the commit state machine. Copies read
    // the registered shadow, so a same-cycle write only lands in the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
                r_target[i] <= '0;
            end
        end else begin
            if (wr_en && w_addr_ok) begin
                r_shadow[wr_addr] <= wr_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (commit) begin
                        r_state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (w_boundary) begin
                        if (fade_en) begin
                            for (int i = 0; i < CH_NUM; i++) begin
                                r_target[i] <= r_shadow[i];
                            end
                            r_state <= S_FADING;
                        end else begin
                            for (int i = 0; i < CH_NUM; i++) begin
                                r_active[i] <= r_shadow[i];
                            end
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_FADING: begin
                    if (w_boundary) begin
                        for (int i = 0; i < CH_NUM; i++) begin
                            r_active[i] <= w_next[i];
                            r_target[i] <= w_tgt_eff[i];
                        end
                        // A commit landing on the boundary itself is held for the next one.
                        r_pend <= commit;
                        if (w_all_eq && !commit) begin
                            r_state <= S_IDLE;
                        end
                    end else if (commit) begin
                        r_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

    // All-ones and zero duties are forced so they stay solid through the
    // counter value where the compare alone would toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_pwm_o <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (r_active[i] == CNT_MAX) begin
                    led_pwm_o[i] <= 1'b1;
                end else if (r_active[i] == '0) begin
                    led_pwm_o[i] <= 1'b0;
                end else begin
                    led_pwm_o[i] <= (r_cnt < r_active[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_engine.sv
// tb/tb_led_pwm_engine.sv - directed self-checking bench for led_pwm_engine

module tb_led_pwm_engine;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       fade_en;
    logic [3:0] fade_step;
    logic       period_start_o;
    logic       busy_o;
    logic [3:0] led_pwm_o;

    int n_checks = 0;
    int n_errors = 0;
    int hi [4];
    int n;
    int nb;
    int total;

    led_pwm_engine #(
        .CH_NUM   (4),
        .PWM_BITS (4),
        .ADDR_W   (2),
        .PRESCALE (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .fade_en        (fade_en),
        .fade_step      (fade_step),
        .period_start_o (period_start_o),
        .busy_o         (busy_o),
        .led_pwm_o      (led_pwm_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Returns at the negedge where period_start_o is high (first cycle of a period).
    task automatic wait_boundary(input string tag, output int ncyc);
        bit found;
        found = 1'b0;
        ncyc  = 0;
        while (!found && ncyc < 80) begin
            @(negedge clk);
            ncyc++;
            if (period_start_o) found = 1'b1;
        end
        check({tag, "_seen"}, int'(found), 1);
    endtask

    // Called on the first cycle of a period; counts high cycles of the
    // period's output window and returns on the first cycle of the next one.
    task automatic measure();
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) hi[c] += int'(led_pwm_o[c]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        commit    = 1'b0;
        fade_en   = 1'b0;
        fade_step = '0;

        // Reset state and first boundary timing.
        repeat (3) @(negedge clk);
        check("rst_led", int'(led_pwm_o), 0);
        check("rst_period_start", int'(period_start_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;
        wait_boundary("first", n);
        check("first_boundary_cycles", n, 32);

        // Immediate commit: ch0=8, ch2=5.
        wr(2'd0, 4'd8);
        wr(2'd2, 4'd5);
        do_commit();
        check("imm_busy_pending", int'(busy_o), 1);
        wait_boundary("imm", n);
        check("imm_busy_after", int'(busy_o), 0);
        measure();
        check("imm_ch0", hi[0], 16);
        check("imm_ch1", hi[1], 0);
        check("imm_ch2", hi[2], 10);
        check("imm_ch3", hi[3], 0);

        // Saturated duties: ch1=15 solid high, ch2=0 solid low over 3 periods.
        wr(2'd1, 4'd15);
        wr(2'd2, 4'd0);
        do_commit();
        wait_boundary("sat", n);
        total = 0;
        n = 0;
        for (int p = 0; p < 3; p++) begin
            measure();
            total += hi[1];
            n += hi[2];
        end
        check("sat_ch1_high", total, 96);
        check("sat_ch2_low", n, 0);
        check("sat_ch0_last", hi[0], 16);

        // Fade 0 -> 10 with step 4.
        wr(2'd0, 4'd0);
        do_commit();
        wait_boundary("fup_clr", n);
        wr(2'd0, 4'd10);
        fade_en   = 1'b1;
        fade_step = 4'd4;
        do_commit();
        wait_boundary("fup", n);
        check("fup_busy_p0", int'(busy_o), 1);
        measure();
        check("fup_ch0_p0", hi[0], 0);
        check("fup_busy_p1", int'(busy_o), 1);
        measure();
        check("fup_ch0_p1", hi[0], 8);
        check("fup_busy_p2", int'(busy_o), 1);
        measure();
        check("fup_ch0_p2", hi[0], 16);
        check("fup_busy_p3", int'(busy_o), 0);
        measure();
        check("fup_ch0_p3", hi[0], 20);

        // Fade 12 -> 2 with step 0 (acts as 1): ten boundaries.
        fade_en = 1'b0;
        wr(2'd0, 4'd12);
        do_commit();
        wait_boundary("fdn_set", n);
        wr(2'd0, 4'd2);
        fade_en   = 1'b1;
        fade_step = 4'd0;
        do_commit();
        wait_boundary("fdn_start", n);
        check("fdn_busy_start", int'(busy_o), 1);
        nb = 0;
        do begin
            wait_boundary("fdn", n);
            nb++;
        end while (busy_o && nb < 20);
        check("fdn_periods", nb, 10);
        measure();
        check("fdn_ch0_final", hi[0], 4);

        // Retarget during fade: 2 -> 14 step 3, then commit 6 while active is 8.
        wr(2'd0, 4'd14);
        fade_step = 4'd3;
        do_commit();
        wait_boundary("rt_start", n);
        wait_boundary("rt_p1", n);
        measure();
        check("rt_ch0_p1", hi[0], 10);
        wr(2'd0, 4'd6);
        do_commit();
        check("rt_busy_mid", int'(busy_o), 1);
        wait_boundary("rt_p3", n);
        check("rt_busy_done", int'(busy_o), 0);
        measure();
        check("rt_ch0_final", hi[0], 12);
        check("rt_ch1_final", hi[1], 32);

        // Shadow write on the boundary-copy cycle.
        fade_en = 1'b0;
        wr(2'd3, 4'd5);
        do_commit();
        repeat (29) @(negedge clk);
        wr(2'd3, 4'd12);
        check("bc_align", int'(period_start_o), 1);
        measure();
        check("bc_ch3_old", hi[3], 10);
        do_commit();
        wait_boundary("bc_next", n);
        measure();
        check("bc_ch3_new", hi[3], 24);

        // Reset mid-fade.
        fade_en   = 1'b1;
        fade_step = 4'd1;
        wr(2'd0, 4'd15);
        do_commit();
        wait_boundary("rf_start", n);
        wait_boundary("rf_p1", n);
        repeat (5) @(negedge clk);
        check("rf_busy_before", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        check("rf_led", int'(led_pwm_o), 0);
        check("rf_busy", int'(busy_o), 0);
        check("rf_period_start", int'(period_start_o), 0);
        fade_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_boundary("rf_after", n);
        check("rf_first_boundary_cycles", n, 32);
        check("rf_busy_after", int'(busy_o), 0);
        measure();
        check("rf_led_sum", hi[0] + hi[1] + hi[2] + hi[3], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
